// File: rtl/dscrptr_src_arb_mux.sv
// rtl/dscrptr_src_arb_mux.sv - N-source descriptor arbiter/mux (round-robin or fixed priority)
// Picks one requester, fetches or takes its descriptor, issues it downstream and pulses gnt/inv.
module dscrptr_src_arb_mux #(
  parameter int NUM_SRC           = 4,
  parameter int SRC_ID_WIDTH      = 2,
  parameter int DSCRPTR_NUM_WIDTH = 2,
  parameter int DSCRPTR_WIDTH     = 133,
  parameter int VALID_BIT_POS     = 0,
  parameter int ARB_MODE          = 0
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_SRC-1:0]                     src_req,
  input  logic [NUM_SRC-1:0]                     src_strm,
  input  logic [NUM_SRC*DSCRPTR_NUM_WIDTH-1:0]   src_dscrptr_num,
  input  logic [NUM_SRC*32-1:0]                  src_strm_addr,
  input  logic [NUM_SRC*DSCRPTR_WIDTH-1:0]       src_dscrptr,
  output logic [NUM_SRC-1:0]                     src_gnt,
  output logic [NUM_SRC-1:0]                     src_inv,
  output logic                                   int_rd_req,
  output logic [DSCRPTR_NUM_WIDTH-1:0]           int_rd_num,
  input  logic                                   int_rd_vld,
  input  logic [DSCRPTR_WIDTH-1:0]               int_rd_data,
  output logic                                   dscrptr_vld,
  input  logic                                   dscrptr_rdy,
  output logic [DSCRPTR_WIDTH-1:0]               dscrptr,
  output logic [DSCRPTR_NUM_WIDTH-1:0]           dscrptr_num,
  output logic                                   dscrptr_strm,
  output logic [31:0]                            dscrptr_strm_addr,
  output logic [SRC_ID_WIDTH-1:0]                dscrptr_src_id,
  output logic                                   busy
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_RELEASE, S_INVALID} state_t;

  localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);

  state_t                         state_q;
  logic [SRC_ID_WIDTH-1:0]        ptr_q, id_q;
  logic [DSCRPTR_NUM_WIDTH-1:0]   num_q;
  logic                           strm_q, vld_q, rd_req_q, busy_q;
  logic [31:0]                    addr_q;
  logic [DSCRPTR_WIDTH-1:0]       dscrptr_q;
  logic [NUM_SRC-1:0]             gnt_q, inv_q;

  logic [SRC_ID_WIDTH-1:0]        base, hi_id, lo_id, win_id;
  logic                           hi_found, lo_found;
  logic [DSCRPTR_NUM_WIDTH-1:0]   win_num;
  logic                           win_strm;
  logic [31:0]                    win_addr;
  logic [DSCRPTR_WIDTH-1:0]       win_dscrptr;

  // Round-robin: first requester at or above the pointer, else lowest overall (wrap-around).
  always_comb begin
    base     = (ARB_MODE == 0) ? ptr_q : '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_req[i]) begin
        lo_found = 1'b1;
        lo_id    = SRC_ID_WIDTH'(i);
        if (i >= int'(base)) begin
          hi_found = 1'b1;
          hi_id    = SRC_ID_WIDTH'(i);
        end
      end
    end
    win_id      = hi_found ? hi_id : lo_id;
    win_num     = '0;
    win_strm    = 1'b0;
    win_addr    = '0;
    win_dscrptr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SRC_ID_WIDTH'(i) == win_id) begin
        win_num     = src_dscrptr_num[i*DSCRPTR_NUM_WIDTH +: DSCRPTR_NUM_WIDTH];
        win_strm    = src_strm[i];
        win_addr    = src_strm_addr[i*32 +: 32];
        win_dscrptr = src_dscrptr[i*DSCRPTR_WIDTH +: DSCRPTR_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      num_q     <= '0;
      strm_q    <= 1'b0;
      addr_q    <= '0;
      dscrptr_q <= '0;
      vld_q     <= 1'b0;
      rd_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      gnt_q     <= '0;
      inv_q     <= '0;
    end else begin
      gnt_q <= '0;
      inv_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (lo_found) begin
            id_q   <= win_id;
            num_q  <= win_num;
            strm_q <= win_strm;
            addr_q <= win_strm ? win_addr : 32'd0;
            busy_q <= 1'b1;
            if (win_strm) begin
              dscrptr_q <= win_dscrptr;
              if (win_dscrptr[VALID_BIT_POS]) begin
                state_q <= S_ISSUE;
                vld_q   <= 1'b1;
              end else begin
                state_q <= S_INVALID;
                inv_q   <= ONE_HOT0 << win_id;
              end
            end else begin
              state_q  <= S_FETCH;
              rd_req_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (int_rd_vld) begin
            rd_req_q  <= 1'b0;
            dscrptr_q <= int_rd_data;
            if (int_rd_data[VALID_BIT_POS]) begin
              state_q <= S_ISSUE;
              vld_q   <= 1'b1;
            end else begin
              state_q <= S_INVALID;
              inv_q   <= ONE_HOT0 << id_q;
            end
          end
        end
        S_ISSUE: begin
          if (dscrptr_rdy) begin
            state_q <= S_RELEASE;
            vld_q   <= 1'b0;
            gnt_q   <= ONE_HOT0 << id_q;
          end
        end
        default: begin
          // RELEASE and INVALID both finish the transaction and advance the pointer.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (ARB_MODE == 0)
            ptr_q <= (id_q == SRC_ID_WIDTH'(NUM_SRC - 1)) ? '0 : id_q + 1'b1;
        end
      endcase
    end
  end

  assign src_gnt           = gnt_q;
  assign src_inv           = inv_q;
  assign int_rd_req        = rd_req_q;
  assign int_rd_num        = num_q;
  assign dscrptr_vld       = vld_q;
  assign dscrptr           = dscrptr_q;
  assign dscrptr_num       = num_q;
  assign dscrptr_strm      = strm_q;
  assign dscrptr_strm_addr = addr_q;
  assign dscrptr_src_id    = id_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_dscrptr_src_arb_mux.sv
// tb/tb_dscrptr_src_arb_mux.sv - bench for dscrptr_src_arb_mux
// Round-robin instance checked against a modulo-search model; fixed-priority instance alongside.
module tb_dscrptr_src_arb_mux;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int NW = 2;
  localparam int DW = 133;

  logic clk, reset;
  logic [N-1:0]    src_req, src_strm;
  logic [N*NW-1:0] src_dscrptr_num;
  logic [N*32-1:0] src_strm_addr;
  logic [N*DW-1:0] src_dscrptr;
  logic            int_rd_vld, dscrptr_rdy;
  logic [DW-1:0]   int_rd_data;

  logic [N-1:0]  a_gnt, a_inv, b_gnt, b_inv;
  logic          a_rd_req, a_vld, a_strm, a_busy, b_rd_req, b_vld, b_strm, b_busy;
  logic [NW-1:0] a_rd_num, a_num, b_rd_num, b_num;
  logic [DW-1:0] a_dsc, b_dsc;
  logic [31:0]   a_addr, b_addr;
  logic [IW-1:0] a_id, b_id;

  logic [DW-1:0] sdesc [N];
  logic [NW-1:0] snum  [N];
  logic [31:0]   saddr [N];
  logic [DW-1:0] mem   [4];
  int            ptr;
  int            checks = 0;
  int            errors = 0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_dscrptr[i*DW +: DW]     = sdesc[i];
      src_dscrptr_num[i*NW +: NW] = snum[i];
      src_strm_addr[i*32 +: 32]   = saddr[i];
    end
  end

  dscrptr_src_arb_mux #(.NUM_SRC(N), .SRC_ID_WIDTH(IW), .DSCRPTR_NUM_WIDTH(NW),
                        .DSCRPTR_WIDTH(DW), .VALID_BIT_POS(0), .ARB_MODE(0)) dut_rr (
    .clock(clk), .reset(reset), .src_req(src_req), .src_strm(src_strm),
    .src_dscrptr_num(src_dscrptr_num), .src_strm_addr(src_strm_addr), .src_dscrptr(src_dscrptr),
    .src_gnt(a_gnt), .src_inv(a_inv), .int_rd_req(a_rd_req), .int_rd_num(a_rd_num),
    .int_rd_vld(int_rd_vld), .int_rd_data(int_rd_data), .dscrptr_vld(a_vld),
    .dscrptr_rdy(dscrptr_rdy), .dscrptr(a_dsc), .dscrptr_num(a_num), .dscrptr_strm(a_strm),
    .dscrptr_strm_addr(a_addr), .dscrptr_src_id(a_id), .busy(a_busy));

  dscrptr_src_arb_mux #(.NUM_SRC(N), .SRC_ID_WIDTH(IW), .DSCRPTR_NUM_WIDTH(NW),
                        .DSCRPTR_WIDTH(DW), .VALID_BIT_POS(0), .ARB_MODE(1)) dut_fp (
    .clock(clk), .reset(reset), .src_req(src_req), .src_strm(src_strm),
    .src_dscrptr_num(src_dscrptr_num), .src_strm_addr(src_strm_addr), .src_dscrptr(src_dscrptr),
    .src_gnt(b_gnt), .src_inv(b_inv), .int_rd_req(b_rd_req), .int_rd_num(b_rd_num),
    .int_rd_vld(int_rd_vld), .int_rd_data(int_rd_data), .dscrptr_vld(b_vld),
    .dscrptr_rdy(dscrptr_rdy), .dscrptr(b_dsc), .dscrptr_num(b_num), .dscrptr_strm(b_strm),
    .dscrptr_strm_addr(b_addr), .dscrptr_src_id(b_id), .busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rand_desc(input bit valid);
    logic [DW-1:0] d;
    for (int b = 0; b < DW; b++) d[b] = 1'($urandom_range(0, 1));
    d[0] = valid;
    return d;
  endfunction

  // Round-robin reference: scan from ptr upward, modulo N.
  function automatic int model_pick();
    for (int k = 0; k < N; k++)
      if (src_req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic run_txn(input int rd_stall, input int rdy_stall, input bit hold);
    int w;
    logic [DW-1:0] d;
    logic [N-1:0] oh;
    w  = model_pick();
    oh = N'(1) << w;
    d  = src_strm[w] ? sdesc[w] : mem[snum[w]];
    dscrptr_rdy = (rdy_stall == 0);
    step();
    check("busy_set", a_busy, 1);
    if (!src_strm[w]) begin
      check("rd_req", a_rd_req, 1);
      check("rd_num", a_rd_num, snum[w]);
      check("vld_in_fetch", a_vld, 0);
      repeat (rd_stall) begin
        step();
        check("rd_req_held", a_rd_req, 1);
      end
      int_rd_vld  = 1'b1;
      int_rd_data = mem[snum[w]];
      step();
      int_rd_vld  = 1'b0;
      int_rd_data = rand_desc(1'b1);
      check("rd_req_drop", a_rd_req, 0);
    end
    if (d[0]) begin
      check("vld", a_vld, 1);
      check("dscrptr", a_dsc, d);
      check("num", a_num, snum[w]);
      check("strm", a_strm, src_strm[w]);
      check("addr", a_addr, src_strm[w] ? saddr[w] : 32'd0);
      check("src_id", a_id, w);
      repeat (rdy_stall) begin
        step();
        check("vld_stall", a_vld, 1);
        check("dscrptr_stable", a_dsc, d);
        check("no_early_gnt", a_gnt, 0);
      end
      dscrptr_rdy = 1'b1;
      step();
      check("vld_drop", a_vld, 0);
      check("gnt", a_gnt, oh);
      check("no_inv", a_inv, 0);
    end else begin
      check("inv", a_inv, oh);
      check("vld_never", a_vld, 0);
      check("no_gnt", a_gnt, 0);
    end
    if (!hold) src_req[w] = 1'b0;
    ptr = (w + 1) % N;
    step();
    check("gnt_one_cycle", a_gnt, 0);
    check("inv_one_cycle", a_inv, 0);
    check("busy_clear", a_busy, 0);
  endtask

  task automatic all_stream_valid();
    for (int i = 0; i < N; i++) begin
      sdesc[i] = rand_desc(1'b1);
      saddr[i] = $urandom;
      snum[i]  = NW'(i);
    end
    src_strm = '1;
  endtask

  initial begin
    int seq [3];
    int exp_id, got;
    reset = 1'b1; src_req = '0; src_strm = '0; int_rd_vld = 1'b0; dscrptr_rdy = 1'b0;
    int_rd_data = '0; ptr = 0;
    for (int i = 0; i < N; i++) begin
      sdesc[i] = '0; snum[i] = '0; saddr[i] = '0; mem[i] = rand_desc(1'b1);
    end
    #1;
    check("rst_busy", a_busy, 0);
    check("rst_vld", a_vld, 0);
    check("rst_gnt", a_gnt, 0);
    check("rst_rd_req", a_rd_req, 0);
    check("rst_dscrptr", a_dsc, 0);
    step();
    reset = 1'b0;

    // Stream single from src 0.
    src_req = 4'b0001; src_strm = 4'b0001;
    sdesc[0] = rand_desc(1'b1); saddr[0] = 32'h1000_0040;
    run_txn(0, 0, 1'b0);

    // Internal fetch from src 2, num 3, with read and ready stalls.
    src_req = 4'b0100; src_strm = 4'b0000; snum[2] = 2'd3; mem[3] = rand_desc(1'b1);
    run_txn(4, 5, 1'b0);

    // Invalid internal descriptor, then a normal stream request.
    src_req = 4'b0001; snum[0] = 2'd1; mem[1] = rand_desc(1'b0);
    run_txn(1, 0, 1'b0);
    src_req = 4'b1000; src_strm = 4'b1000; sdesc[3] = rand_desc(1'b1); saddr[3] = $urandom;
    run_txn(0, 0, 1'b0);

    // Round-robin fairness with all sources held.
    all_stream_valid();
    src_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      check("rr_order", 32'(model_pick()), k % N);
      run_txn(0, 0, 1'b1);
    end
    src_req = '0;

    // Reset mid-ISSUE from src 2 (pointer currently 1).
    src_req = 4'b0100; dscrptr_rdy = 1'b0;
    step();
    check("pre_rst_vld", a_vld, 1);
    reset = 1'b1;
    #1;
    check("arst_vld", a_vld, 0);
    check("arst_busy", a_busy, 0);
    check("arst_id", a_id, 0);
    check("arst_addr", a_addr, 0);
    check("arst_dscrptr", a_dsc, 0);
    @(negedge clk);
    reset = 1'b0; ptr = 0; src_req = 4'b1111;
    check("post_rst_gnt", a_gnt, 0);
    check("post_rst_inv", a_inv, 0);
    check("first_rr_winner", 32'(model_pick()), 0);
    run_txn(0, 0, 1'b0);
    src_req = '0;

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) begin
        sdesc[i] = rand_desc($urandom_range(0, 3) != 0);
        mem[i]   = rand_desc($urandom_range(0, 3) != 0);
        snum[i]  = NW'($urandom_range(0, 3));
        saddr[i] = $urandom;
      end
      src_strm = N'($urandom_range(0, 15));
      src_req  = N'($urandom_range(1, 15));
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
    src_req = '0;

    // Fixed priority instance: 1010 held -> 1, 1, then 3 once req[1] drops.
    reset = 1'b1;
    step();
    reset = 1'b0; ptr = 0;
    all_stream_valid();
    dscrptr_rdy = 1'b1;
    src_req = 4'b1010;
    for (int g = 0; g < 3; g++) begin
      exp_id = -1;
      for (int i = N - 1; i >= 0; i--) if (src_req[i]) exp_id = i;
      got = -1;
      for (int c = 0; c < 8 && got < 0; c++) begin
        step();
        if (b_gnt != '0) got = 0;
      end
      if (got < 0) check("fp_timeout", 0, 1);
      else check("fp_gnt", b_gnt, N'(1) << exp_id);
      seq[g] = exp_id;
      if (g == 1) src_req[1] = 1'b0;
    end
    check("fp_seq_last", 32'(seq[2]), 3);
    src_req = '0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dscrptr_src_arb_mux.md
Name: dscrptr_src_arb_mux

Overview:
- Parametrised N-source descriptor source arbiter/mux for the AXI4 DMA controller; generalises the fixed 3-requester descriptor source mux.
- Sits between descriptor requesters (internal BD queues, stream descriptor ports) and the channel controller.
- Arbitrates by round-robin or fixed priority, fetches internal descriptors from the descriptor store, checks the valid bit, forwards one descriptor at a time downstream, and returns grant/invalid status to the winning source.

Parameters:
NUM_SRC, 4, number of requesting sources (2..16)
SRC_ID_WIDTH, 2, width of source index; must be >= clog2(NUM_SRC)
DSCRPTR_NUM_WIDTH, 2, internal descriptor number width
DSCRPTR_WIDTH, 133, descriptor width
VALID_BIT_POS, 0, descriptor bit that flags a valid descriptor
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
src_req  in  NUM_SRC  per-source request; held until src_gnt or src_inv
src_strm  in  NUM_SRC  1 = stream source, which supplies the descriptor itself
src_dscrptr_num  in  NUM_SRC*DSCRPTR_NUM_WIDTH  flat per-source descriptor number
src_strm_addr  in  NUM_SRC*32  flat per-source stream address
src_dscrptr  in  NUM_SRC*DSCRPTR_WIDTH  flat per-source stream descriptor
src_gnt  out  NUM_SRC  one-cycle one-hot pulse: descriptor accepted downstream
src_inv  out  NUM_SRC  one-cycle one-hot pulse: descriptor invalid, dropped
int_rd_req  out  1  internal descriptor read request
int_rd_num  out  DSCRPTR_NUM_WIDTH  descriptor number being read
int_rd_vld  in  1  read data valid (single-cycle)
int_rd_data  in  DSCRPTR_WIDTH  internal descriptor
dscrptr_vld  out  1  descriptor valid to channel controller
dscrptr_rdy  in  1  channel controller accepts
dscrptr  out  DSCRPTR_WIDTH  descriptor
dscrptr_num  out  DSCRPTR_NUM_WIDTH  descriptor number
dscrptr_strm  out  1  1 = stream descriptor
dscrptr_strm_addr  out  32  stream address; 0 for internal descriptors
dscrptr_src_id  out  SRC_ID_WIDTH  winning source index
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: every output 0; FSM to IDLE; round-robin pointer to 0; capture registers cleared. Reset mid-operation aborts silently, with no gnt/inv pulse.
- All outputs are registered. Winner fields (id, num, strm, addr) are captured in the arbitration cycle and held until RELEASE/INVALID.
- FSM states: IDLE, FETCH, ISSUE, RELEASE, INVALID.
- IDLE:
  - If any src_req, pick a winner and capture its fields.
  - Stream winner: capture src_dscrptr, then go to ISSUE if the valid bit is set, else INVALID.
  - Internal winner: go to FETCH.
- FETCH:
  - int_rd_req = 1 and int_rd_num = captured num, held until int_rd_vld.
  - On int_rd_vld: capture int_rd_data and drop int_rd_req in the next cycle.
  - Next state is ISSUE if int_rd_data[VALID_BIT_POS] is set, else INVALID.
- ISSUE:
  - dscrptr_vld = 1; all dscrptr_* outputs stable while waiting.
  - On dscrptr_vld && dscrptr_rdy go to RELEASE.
  - Zero back-pressure case: ISSUE lasts one cycle.
- RELEASE: src_gnt[winner] = 1 for one cycle; update pointer; go to IDLE.
- INVALID: src_inv[winner] = 1 for one cycle; update pointer; go to IDLE; dscrptr_vld is never raised.
- Round-robin:
  - Search starts at the pointer and wraps modulo NUM_SRC.
  - After completion, pointer = winner+1, wrapping NUM_SRC-1 -> 0.
  - The pointer is never updated on reset abort.
- Fixed priority: lowest asserted index wins; pointer is unused.
- Requests are sampled only in IDLE. A req deasserted mid-transaction is ignored and the transaction completes.
- A request from the winner is not re-serviced in the cycle its gnt/inv pulses; IDLE is re-entered first.
- Latency from req to dscrptr_vld:
  - Stream source: 2 cycles (IDLE sample, ISSUE).
  - Internal source: 3 cycles plus the int_rd_vld wait.
- Minimum turnaround per descriptor: 3 cycles (IDLE, ISSUE, RELEASE).
- Out-of-range num/id values are passed through unchecked.

Test Plan:
- Reset: assert reset mid-ISSUE -> all outputs 0 at once; after release busy=0 and the first round-robin winner is src 0.
- Stream single: src_req=0001, src_strm=0001, src_dscrptr bit0=1, addr=0x1000_0040, dscrptr_rdy=1 -> dscrptr_vld 2 cycles after req, strm=1, addr=0x1000_0040, src_id=0, src_gnt=0001 one cycle later.
- Internal fetch with stall: src_req=0100, num=3, int_rd_vld 4 cycles after int_rd_req, data bit0=1, dscrptr_rdy held 0 for 5 cycles -> int_rd_num=3; dscrptr held stable; single src_gnt=0100 pulse.
- Invalid: internal read returns bit0=0 -> src_inv pulses for that source, dscrptr_vld stays 0, next request is served normally.
- Round-robin fairness: src_req=1111 held, rdy=1, ARB_MODE=0 -> grants in order 0,1,2,3,0; pointer wraps 3->0.
- Fixed priority: ARB_MODE=1, src_req=1010 held -> src 1 granted repeatedly; src 3 granted only after src_req[1] drops.
